// File: rtl/iter_alu_pkg.sv
// Shared ALU definitions: opcode encodings, controller state encoding and the
// default datapath width. Imported by the ALU and by the control unit so both
// sides agree on opcode values.
package iter_alu_pkg;

   localparam int ALU_WIDTH_DEF = 12;
   localparam int OP_W          = 3;

   localparam logic [OP_W-1:0] OP_PASS = 3'd0;
   localparam logic [OP_W-1:0] OP_ADD  = 3'd1;
   localparam logic [OP_W-1:0] OP_SUB  = 3'd2;
   localparam logic [OP_W-1:0] OP_AND  = 3'd3;
   localparam logic [OP_W-1:0] OP_MUL  = 3'd4;
   localparam logic [OP_W-1:0] OP_DIV  = 3'd5;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_e;

endpackage

// File: rtl/iter_alu_div.sv
// Restoring divider datapath: one quotient bit per step, WIDTH steps per divide.
// Latency: loaded on one edge, quotient complete on the WIDTH-th step edge.
// No backpressure: the parent drives load/step and owns sequencing.
// Ports: clk, rstN (async active-low), load (capture operands), step (one
// iteration), dvd/dvs (dividend/divisor), quo (quotient as it will stand after
// the current step; all ones when the divisor is zero).
module iter_div
   import iter_alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dvd,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] quo
);

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             dz_q, dz_d;

   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] diff;
   logic             fits;
   logic [WIDTH-1:0] quo_nxt;
   logic [WIDTH-1:0] rem_nxt;

   // quo_q starts as the dividend and shifts left; its MSB feeds the
   // partial remainder while quotient bits fill in from the bottom.
   always_comb begin
      rem_sh  = {rem_q, quo_q[WIDTH-1]};
      fits    = (rem_sh >= {1'b0, dvs_q});
      // rem_sh < 2*dvs whenever it fits, so the low WIDTH bits hold the
      // exact difference.
      diff    = rem_sh[WIDTH-1:0] - dvs_q;
      rem_nxt = fits ? diff : rem_sh[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], fits};
      quo     = dz_q ? {WIDTH{1'b1}} : quo_nxt;
   end

   always_comb begin
      rem_d = rem_q;
      quo_d = quo_q;
      dvs_d = dvs_q;
      dz_d  = dz_q;
      if (load) begin
         rem_d = '0;
         quo_d = dvd;
         dvs_d = dvs;
         dz_d  = (dvs == '0);
      end else if (step) begin
         rem_d = rem_nxt;
         quo_d = quo_nxt;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         dz_q  <= 1'b0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
         dz_q  <= dz_d;
      end
   end

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle ALU feeding the Z-flag register: PASS/ADD/SUB/AND in one clock,
// MUL (shift-add) and DIV (restoring) in WIDTH clocks. zWrEn pulses with done.
// Backpressure: start is ignored while busy; no queueing.
// Ports: clk, rstN (async active-low), start/op/aIn/bIn (request, sampled when
// idle), result (held until next completion), busy, done, zWrEn.
// Build option: define ITER_ALU_DIV_EN to include the divider; without it
// op 5 behaves as an illegal opcode (single cycle, result 0).
module iter_alu
   import iter_alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH_DEF,   // minimum 4
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] aIn,
   input  logic [WIDTH-1:0] bIn,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             zWrEn
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             is_div_q, is_div_d;

   logic [WIDTH-1:0] acc_nxt;
   logic             div_load;
   logic             div_step;
   logic [WIDTH-1:0] div_quo;

`ifdef ITER_ALU_DIV_EN
   iter_div #(
      .WIDTH (WIDTH)
   ) u_div (
      .clk  (clk),
      .rstN (rstN),
      .load (div_load),
      .step (div_step),
      .dvd  (aIn),
      .dvs  (bIn),
      .quo  (div_quo)
   );
`else
   assign div_quo = '0;
`endif

   // One shift-add step: only the low WIDTH product bits are kept, so the
   // multiplicand may shift out of range without affecting the result.
   assign acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      done_d   = 1'b0;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      is_div_d = is_div_q;
      div_load = 1'b0;
      div_step = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               case (op)
                  OP_PASS: begin
                     result_d = aIn;
                     done_d   = 1'b1;
                  end
                  OP_ADD: begin
                     result_d = aIn + bIn;
                     done_d   = 1'b1;
                  end
                  OP_SUB: begin
                     result_d = aIn - bIn;
                     done_d   = 1'b1;
                  end
                  OP_AND: begin
                     result_d = aIn & bIn;
                     done_d   = 1'b1;
                  end
                  OP_MUL: begin
                     mcand_d  = aIn;
                     mplier_d = bIn;
                     acc_d    = '0;
                     cnt_d    = '0;
                     is_div_d = 1'b0;
                     state_d  = CALC;
                  end
`ifdef ITER_ALU_DIV_EN
                  OP_DIV: begin
                     div_load = 1'b1;
                     cnt_d    = '0;
                     is_div_d = 1'b1;
                     state_d  = CALC;
                  end
`endif
                  default: begin
                     result_d = '0;
                     done_d   = 1'b1;
                  end
               endcase
            end
         end

         CALC: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (is_div_q) begin
               div_step = 1'b1;
            end else begin
               acc_d    = acc_nxt;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
            end
            // cnt_q counts iterations already done; this edge performs the last.
            if (cnt_q == CNT_LAST) begin
               result_d = is_div_q ? div_quo : acc_nxt;
               done_d   = 1'b1;
               cnt_d    = '0;
               state_d  = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         is_div_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         done_q   <= done_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         is_div_q <= is_div_d;
      end
   end

   assign result = result_q;
   assign busy   = (state_q == CALC);
   assign done   = done_q;
   assign zWrEn  = done_q;

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu at the default width (12 bits).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// A small Z register model shows what the downstream flag register captures.
module tb_iter_alu;

   localparam int W = 12;

   logic          clk;
   logic          rstN;
   logic          start;
   logic [2:0]    op;
   logic [W-1:0]  aIn;
   logic [W-1:0]  bIn;
   logic [W-1:0]  result;
   logic          busy;
   logic          done;
   logic          zWrEn;

   logic          z_reg;
   int            checks;
   int            errors;
   int            n;
   int            done_seen;

   iter_alu dut (
      .clk    (clk),
      .rstN   (rstN),
      .start  (start),
      .op     (op),
      .aIn    (aIn),
      .bIn    (bIn),
      .result (result),
      .busy   (busy),
      .done   (done),
      .zWrEn  (zWrEn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream Z flag register: dataIn = (result == 0), wrEn = zWrEn.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) z_reg <= 1'b0;
      else if (zWrEn) z_reg <= (result == '0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Count busy cycles from the current point until busy drops, bounded.
   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < 40) begin
         cycles++;
         tick();
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      start = 1'b1;
      op    = o;
      aIn   = a;
      bIn   = b;
      tick();
      start = 1'b0;
      op    = 3'd0;
      aIn   = '0;
      bIn   = '0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rstN   = 1'b0;
      start  = 1'b0;
      op     = 3'd0;
      aIn    = '0;
      bIn    = '0;

      #12;
      chk("reset_result", 32'(result), 32'h0);
      chk("reset_busy",   32'(busy),   32'h0);
      chk("reset_done",   32'(done),   32'h0);
      chk("reset_zwren",  32'(zWrEn),  32'h0);
      tick();
      rstN = 1'b1;
      tick();

      // ADD wrapping to zero: result one clock after the start edge.
      issue(3'd1, 12'h7FF, 12'h801);
      chk("add_wrap_result", 32'(result), 32'h000);
      chk("add_done",        32'(done),   32'h1);
      chk("add_zwren",       32'(zWrEn),  32'h1);
      tick();
      chk("add_done_clear",  32'(done),   32'h0);
      chk("add_z_reg",       32'(z_reg),  32'h1);

      // PASS / AND / illegal
      issue(3'd0, 12'h123, 12'hABC);
      chk("pass_result", 32'(result), 32'h123);
      issue(3'd3, 12'hF0F, 12'h0FF);
      chk("and_result",  32'(result), 32'h00F);
      tick();
      chk("z_after_and", 32'(z_reg),  32'h0);
      issue(3'd7, 12'h555, 12'h333);
      chk("illegal_result", 32'(result), 32'h000);
      chk("illegal_done",   32'(done),   32'h1);

      // SUB back-to-back, second issued in the done cycle of the first.
      start = 1'b1; op = 3'd2; aIn = 12'h005; bIn = 12'h005;
      tick();
      chk("sub0_result", 32'(result), 32'h000);
      chk("sub0_done",   32'(done),   32'h1);
      aIn = 12'h003; bIn = 12'h005;
      tick();
      start = 1'b0;
      chk("sub1_result", 32'(result), 32'hFFE);
      chk("sub1_done",   32'(done),   32'h1);
      tick();
      chk("sub_done_clear", 32'(done), 32'h0);

      // MUL 25 x 40 = 1000
      issue(3'd4, 12'd25, 12'd40);
      chk("mul_busy_start", 32'(busy), 32'h1);
      chk("mul_no_done",    32'(done), 32'h0);
      wait_idle(n);
      chk("mul_busy_cycles", 32'(n),      32'd12);
      chk("mul_result",      32'(result), 32'h3E8);
      chk("mul_done",        32'(done),   32'h1);
      tick();
      chk("mul_done_clear",  32'(done),   32'h0);

      // MUL truncation
      issue(3'd4, 12'hFFF, 12'h002);
      wait_idle(n);
      chk("mul_trunc_cycles", 32'(n),      32'd12);
      chk("mul_trunc_result", 32'(result), 32'hFFE);

      // start during busy is ignored: 10 x 11 = 110
      issue(3'd4, 12'd10, 12'd11);
      tick(); tick(); tick();
      issue(3'd1, 12'd1, 12'd1);
      chk("ignored_busy", 32'(busy), 32'h1);
      chk("ignored_done", 32'(done), 32'h0);
      wait_idle(n);
      chk("ignored_total_cycles", 32'(n + 4), 32'd12);
      chk("ignored_mul_result",   32'(result), 32'h06E);
      tick();

`ifdef ITER_ALU_DIV_EN
      issue(3'd5, 12'd1000, 12'd7);
      chk("div_busy", 32'(busy), 32'h1);
      wait_idle(n);
      chk("div_cycles", 32'(n),      32'd12);
      chk("div_result", 32'(result), 32'h08E);
      chk("div_done",   32'(done),   32'h1);
      tick();
      issue(3'd5, 12'd5, 12'd0);
      wait_idle(n);
      chk("div0_cycles", 32'(n),      32'd12);
      chk("div0_result", 32'(result), 32'hFFF);
`else
      issue(3'd5, 12'd1000, 12'd7);
      chk("div_off_busy",   32'(busy),   32'h0);
      chk("div_off_done",   32'(done),   32'h1);
      chk("div_off_result", 32'(result), 32'h000);
`endif
      tick();

      // Load a nonzero result, then reset in the middle of a MUL.
      issue(3'd0, 12'hA5A, 12'h000);
      chk("pre_reset_result", 32'(result), 32'hA5A);
      issue(3'd4, 12'd25, 12'd40);
      tick(); tick(); tick(); tick(); tick();
      #2;
      rstN = 1'b0;
      #1;
      chk("midreset_busy",   32'(busy),   32'h0);
      chk("midreset_done",   32'(done),   32'h0);
      chk("midreset_result", 32'(result), 32'h000);
      tick();
      tick();
      rstN = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) done_seen++;
      end
      chk("no_pulse_after_reset", 32'(done_seen), 32'd0);
      issue(3'd1, 12'd1, 12'd1);
      chk("post_reset_add", 32'(result), 32'h002);
      chk("post_reset_done", 32'(done),  32'h1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Multi-cycle ALU for each core's datapath.
- Sits directly upstream of the Z-flag register: produces a WIDTH-bit result plus a one-cycle write strobe that drives the Z register's dataIn/wrEn.
- Single-cycle ops (ADD/SUB/PASS/AND) complete in 1 clock; MUL and DIV run iteratively (shift-add / restoring) over WIDTH clocks.
- start/busy/done handshake to the control unit.

Parameters:
- WIDTH, 12, operand/result width in bits (min 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk     input   1      clock; all state updates on rising edge
- rstN    input   1      asynchronous active-low reset
- start   input   1      request; sampled only when busy=0
- op      input   3      opcode, sampled with start
- aIn     input   WIDTH  operand A (dividend/multiplicand), sampled with start
- bIn     input   WIDTH  operand B (divisor/multiplier), sampled with start
- result  output  WIDTH  registered result; holds until next completion
- busy    output  1      high while a MUL/DIV is iterating
- done    output  1      one-cycle pulse when result is updated
- zWrEn   output  1      equals done; connects to Z register wrEn, with result to its dataIn

Behaviour:
- Reset (rstN=0, asynchronous): result=0, busy=0, done=0, zWrEn=0, state=IDLE, counter=0, internal operand/accumulator regs=0.
  - Takes effect mid-iteration with no completion pulse.
  - Release is synchronous to the next edge.
- States: IDLE, CALC. done is a registered flag, not a state.
- Opcodes: 0 PASS(A), 1 ADD, 2 SUB, 3 AND, 4 MUL, 5 DIV, 6-7 illegal.
- IDLE + start=1 at edge k:
  - Single-cycle op or illegal: result registered at edge k; done=1 for the cycle after edge k; stay IDLE.
  - MUL/DIV: operands latched, counter=0, busy=1 after edge k, go CALC.
- CALC: one iteration per edge.
  - The edge performing iteration WIDTH (edge k+WIDTH) writes result, sets done=1, clears busy, returns to IDLE.
  - Total latency is WIDTH clocks (12 at default).
- done and zWrEn are high for exactly one cycle; cleared at the next edge unless a new single-cycle op completes there.
- start while busy=1 is ignored: no queueing, no effect on the operation in flight.
- start in a done=1 cycle is accepted, allowing back-to-back operation.
- Arithmetic:
  - ADD/SUB are modulo 2^WIDTH; carry/borrow is discarded.
  - MUL returns the low WIDTH bits of the unsigned product.
  - DIV returns the unsigned quotient.
  - DIV by zero: full WIDTH iterations, result = all ones.
  - Illegal op: result = 0.
- aIn, bIn and op are don't-care except on the accepting edge.

Optional Feature:
- Macro: ITER_ALU_DIV_EN.
- Defined: DIV (op 5) is implemented as above, using the iter_div sub-module.
- Undefined: no divider hardware. op 5 is treated as illegal: single-cycle, result=0, done after 1 clock, busy never asserted.

Decomposition:
- Shared package/header alu_defs holds:
  - opcode constants OP_PASS..OP_DIV
  - state encodings IDLE/CALC
  - the default WIDTH
- The control unit includes the same header.
- One natural sub-module: iter_div (restoring divider step, remainder/quotient registers, divide-by-zero flag), instantiated only under ITER_ALU_DIV_EN.
- MUL stays inline.

Test Plan:
- Reset then ADD aIn=0x7FF, bIn=0x801 -> result=0x000 one clock after the start edge; done=zWrEn=1 for one cycle; downstream Z register reads 1.
- SUB 0x005-0x005 -> 0x000, then SUB 0x003-0x005 -> 0xFFE, issued back-to-back in the done cycle; two consecutive done pulses.
- MUL 25×40 -> busy=1 for 12 cycles; then result=0x3E8 with done pulse. MUL 0xFFF×0x002 -> 0xFFE (truncated).
- DIV 1000/7 -> 0x08E after 12 cycles; DIV 5/0 -> 0xFFF. With ITER_ALU_DIV_EN undefined: DIV -> 0x000 after 1 cycle, busy stays 0.
- MUL started, start pulsed again with ADD at cycle 4 -> ignored; MUL result is unchanged at cycle 12.
- rstN driven low at cycle 6 of a MUL -> busy, done and result go to 0 immediately with no done pulse. An ADD 1+1 after release -> 0x002.
